wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 112 +++++++++++
 tb/tb_wb_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Write-back queue: merges load-unit and ALU write-back requests into one FIFO
// that drains into the register file, with a pending-write lookup for bypass.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_wa,
    input  logic [31:0]              mem_wd,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_wa,
    input  logic [31:0]              alu_wd,
    input  logic                     wb_hold,
    output logic                     rf_we,
    output logic [4:0]               rf_wa,
    output logic [31:0]              rf_wd,
    input  logic [4:0]               chk_ra1,
    input  logic [4:0]               chk_ra2,
    output logic                     chk_hit1,
    output logic                     chk_hit2,
    output logic [31:0]              chk_data1,
    output logic [31:0]              chk_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       wa_q [DEPTH];
    logic [31:0]      wd_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic        not_full;
    logic        hs;
    logic        push;
    logic        pop;
    logic [4:0]  push_wa;
    logic [31:0] push_wd;

    // Ready depends only on the registered count, so a same-cycle pop can
    // never feed back into the request handshake.
    assign not_full  = (count_q != CNT_W'(DEPTH));
    assign mem_ready = not_full;
    assign alu_ready = not_full && !mem_valid;

    assign hs      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign push_wa = mem_valid ? mem_wa : alu_wa;
    assign push_wd = mem_valid ? mem_wd : alu_wd;
    // Writes to x0 complete the handshake but are dropped.
    assign push    = hs && (push_wa != 5'd0);

    assign rf_we = (count_q != '0) && !wb_hold;
    assign pop   = rf_we;
    assign rf_wa = (count_q != '0) ? wa_q[head_q] : 5'd0;
    assign rf_wd = (count_q != '0) ? wd_q[head_q] : 32'd0;
    assign count = count_q;

    // NOTE: every output of this block gets a default before the loop, so no
    // path leaves a value held and no latch is inferred.
    always_comb begin
        chk_hit1  = 1'b0;
        chk_hit2  = 1'b0;
        chk_data1 = 32'd0;
        chk_data2 = 32'd0;
        // Walk oldest to youngest so the youngest match overwrites earlier ones.
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if (chk_ra1 != 5'd0 && wa_q[head_q + PTR_W'(i)] == chk_ra1) begin
                    chk_hit1  = 1'b1;
                    chk_data1 = wd_q[head_q + PTR_W'(i)];
                end
                if (chk_ra2 != 5'd0 && wa_q[head_q + PTR_W'(i)] == chk_ra2) begin
                    chk_hit2  = 1'b1;
                    chk_data2 = wd_q[head_q + PTR_W'(i)];
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: entry storage has no reset; occupancy alone decides what is valid,
    // which keeps the array free of reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            wa_q[tail_q] <= push_wa;
            wd_q[tail_q] <= push_wd;
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: a reference queue model is checked against
// the DUT every cycle, plus directed scenarios and a random traffic phase.
module tb_wb_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        mem_valid, alu_valid, wb_hold;
    logic        mem_ready, alu_ready;
    logic [4:0]  mem_wa, alu_wa, chk_ra1, chk_ra2, rf_wa;
    logic [31:0] mem_wd, alu_wd, rf_wd, chk_data1, chk_data2;
    logic        rf_we, chk_hit1, chk_hit2;
    logic [$clog2(DEPTH):0] count;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
        .wb_hold(wb_hold),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2),
        .chk_hit1(chk_hit1), .chk_hit2(chk_hit2),
        .chk_data1(chk_data1), .chk_data2(chk_data2),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    ent_t sb[$];
    logic acc_mem = 1'b0;
    logic acc_alu = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_lookup(input logic [4:0] ra, output logic hit,
                                         output logic [31:0] data);
        hit  = 1'b0;
        data = 32'd0;
        if (ra != 5'd0) begin
            foreach (sb[i]) begin
                if (sb[i].wa == ra) begin
                    hit  = 1'b1;
                    data = sb[i].wd;
                end
            end
        end
    endfunction

    // Reference model: checks the DUT mid-cycle, then advances on the coming edge.
    always @(negedge clk) begin
        int          m_cnt;
        logic        m_full, m_we, h1, h2;
        logic [31:0] d1, d2;
        if (rst_n) begin
            m_cnt  = sb.size();
            m_full = (m_cnt >= DEPTH);
            m_we   = (m_cnt != 0) && !wb_hold;
            check("count", 32'(count), m_cnt);
            check("mem_ready", mem_ready, !m_full);
            check("alu_ready", alu_ready, !m_full && !mem_valid);
            check("rf_we", rf_we, m_we);
            check("rf_wa", rf_wa, (m_cnt != 0) ? sb[0].wa : 5'd0);
            check("rf_wd", rf_wd, (m_cnt != 0) ? sb[0].wd : 32'd0);
            model_lookup(chk_ra1, h1, d1);
            model_lookup(chk_ra2, h2, d2);
            check("chk_hit1", chk_hit1, h1);
            check("chk_data1", chk_data1, d1);
            check("chk_hit2", chk_hit2, h2);
            check("chk_data2", chk_data2, d2);
            acc_mem = mem_valid && !m_full;
            acc_alu = alu_valid && !m_full && !mem_valid;
            if (m_we) void'(sb.pop_front());
            if (acc_mem && mem_wa != 5'd0) sb.push_back('{wa: mem_wa, wd: mem_wd});
            if (acc_alu && alu_wa != 5'd0) sb.push_back('{wa: alu_wa, wd: alu_wd});
        end else begin
            acc_mem = 1'b0;
            acc_alu = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_alu(input logic [4:0] wa, input logic [31:0] wd);
        alu_valid = 1'b1;
        alu_wa    = wa;
        alu_wd    = wd;
        for (int n = 0; n < 64; n++) begin
            step();
            if (acc_alu) break;
        end
        alu_valid = 1'b0;
        check("alu_accept", acc_alu, 1'b1);
    endtask

    task automatic send_both(input logic [4:0] mwa, input logic [31:0] mwd,
                             input logic [4:0] awa, input logic [31:0] awd);
        logic mem_done, alu_done;
        mem_done = 1'b0;
        alu_done = 1'b0;
        mem_valid = 1'b1; mem_wa = mwa; mem_wd = mwd;
        alu_valid = 1'b1; alu_wa = awa; alu_wd = awd;
        #1;
        check("alu_ready_blocked", alu_ready, 1'b0);
        for (int n = 0; n < 64 && !(mem_done && alu_done); n++) begin
            step();
            if (acc_mem) begin mem_done = 1'b1; mem_valid = 1'b0; end
            if (acc_alu) begin alu_done = 1'b1; alu_valid = 1'b0; end
        end
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        check("both_accept", {mem_done, alu_done}, 2'b11);
    endtask

    task automatic drain();
        for (int n = 0; n < 64 && sb.size() != 0; n++) step();
        check("drain", sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_valid = 1'b0; alu_valid = 1'b0; wb_hold = 1'b0;
        mem_wa = '0; mem_wd = '0; alu_wa = '0; alu_wd = '0;
        chk_ra1 = '0; chk_ra2 = '0;
        #3;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_count", 32'(count), 0);
        check("rst_mem_ready", mem_ready, 1'b1);
        check("rst_alu_ready", alu_ready, 1'b1);
        #4 rst_n = 1'b1;
        step();

        // Single ALU write retires one cycle after acceptance.
        send_alu(5'd5, 32'hDEADBEEF);
        check("s1_rf_we", rf_we, 1'b1);
        check("s1_rf_wa", rf_wa, 5'd5);
        check("s1_rf_wd", rf_wd, 32'hDEADBEEF);
        step();
        check("s1_rf_we_off", rf_we, 1'b0);
        check("s1_count", 32'(count), 0);

        // Simultaneous requests: load first, ALU next cycle.
        send_both(5'd7, 32'h0000_1111, 5'd8, 32'h0000_2222);
        drain();

        // Fill under hold, then release and drain in order.
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) send_alu(5'(i), 32'hA000_0000 + 32'(i));
        check("s3_count_full", 32'(count), 4);
        check("s3_mem_ready", mem_ready, 1'b0);
        check("s3_alu_ready", alu_ready, 1'b0);
        alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'h9;
        step();
        step();
        alu_valid = 1'b0;
        check("s3_still_full", 32'(count), 4);
        wb_hold = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("s3_empty_after4", 32'(count), 0);

        // Lookup returns the youngest matching write; x0 never hits.
        wb_hold = 1'b1;
        send_alu(5'd3, 32'd1);
        send_alu(5'd3, 32'd2);
        chk_ra1 = 5'd3;
        chk_ra2 = 5'd0;
        #1;
        check("s4_hit1", chk_hit1, 1'b1);
        check("s4_data1", chk_data1, 32'd2);
        check("s4_hit2", chk_hit2, 1'b0);
        wb_hold = 1'b0;
        drain();
        chk_ra1 = 5'd0;

        // Write to x0 completes the handshake but is not queued.
        send_alu(5'd0, 32'h1234);
        check("s5_count", 32'(count), 0);
        check("s5_rf_we", rf_we, 1'b0);

        // Mid-cycle reset discards three queued entries.
        wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) send_alu(5'd10 + 5'(i), 32'hB0 + 32'(i));
        check("s6_count_pre", 32'(count), 3);
        wb_hold = 1'b0;
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        check("s6_count_rst", 32'(count), 0);
        check("s6_rf_we_rst", rf_we, 1'b0);
        check("s6_rf_wa_rst", rf_wa, 5'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Random traffic with hold and lookups; the model checks every cycle.
        for (int c = 0; c < 300; c++) begin
            mem_valid = ($urandom_range(0, 3) == 0);
            mem_wa    = 5'($urandom_range(0, 7));
            mem_wd    = $urandom;
            alu_valid = ($urandom_range(0, 1) == 0);
            alu_wa    = 5'($urandom_range(0, 7));
            alu_wd    = $urandom;
            wb_hold   = ($urandom_range(0, 3) == 0);
            chk_ra1   = 5'($urandom_range(0, 7));
            chk_ra2   = 5'($urandom_range(0, 7));
            step();
        end
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        wb_hold   = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
